// File: rtl/lsu_if.sv
// lsu_if: pipeline-side request/response bundle of the load/store unit
interface lsu_if #(parameter int ADDR_WIDTH = 10);
  logic req_valid, req_ready, MemRead, MemWrite, done, misalign_err;
  logic [2:0] MemLen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] wdata, rdata;
  modport master(output req_valid, MemRead, MemWrite, MemLen, addr, wdata,
                 input req_ready, rdata, done, misalign_err);
  modport slave(input req_valid, MemRead, MemWrite, MemLen, addr, wdata,
                output req_ready, rdata, done, misalign_err);
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store initiator, splits word-crossing accesses into two beats.
// Optional LSU_MISALIGN_TRAP_EN: misaligned word/half accesses trap instead of splitting.
module lsu_ctrl #(parameter int ADDR_WIDTH = 10) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave req,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic mem_re,
  output logic mem_we,
  output logic [3:0] mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [2:0] IDLE = 3'd0, B0 = 3'd1, B1 = 3'd2, WAIT = 3'd3, RESP = 3'd4;
  logic [2:0] state, len_q;
  logic [1:0] o_q;
  logic [ADDR_WIDTH-3:0] idx_q;
  logic [3:0] msk, be1_q;
  logic [7:0] bef;
  logic [63:0] wd64;
  logic [31:0] wd1_q, word0_q, rdata_q, lo, sh, ext;
  logic ld_q, st_q, split_q, done_q, ready, trap, ok, ld_in, st_in;
  assign msk = (req.MemLen == 3'd0 || req.MemLen == 3'd3) ? 4'h1 :
               (req.MemLen == 3'd1 || req.MemLen == 3'd4) ? 4'h3 :
               (req.MemLen == 3'd2) ? 4'hF : 4'h0;
  assign bef = 8'({4'b0, msk} << req.addr[1:0]);
  assign wd64 = {32'b0, req.wdata} << {req.addr[1:0], 3'b0};
`ifdef LSU_MISALIGN_TRAP_EN
  logic trap_q, err_q;
  assign trap = (req.MemWrite || req.MemRead) &&
                ((req.MemLen == 3'd2 && req.addr[1:0] != 2'd0) ||
                 ((req.MemLen == 3'd1 || req.MemLen == 3'd4) && req.addr[0]));
  assign req.misalign_err = err_q;
`else
  assign trap = 1'b0;
  assign req.misalign_err = 1'b0;
`endif
  assign ok = msk != 4'h0 && (req.MemWrite || req.MemRead) && !trap;
  assign st_in = req.MemWrite && ok;
  assign ld_in = !req.MemWrite && req.MemRead && ok;
  assign ready = state == IDLE || state == RESP;
  assign req.req_ready = ready;
  assign req.rdata = rdata_q;
  assign req.done = done_q;
  // In WAIT the RAM output holds the last word; word0 was captured earlier only for splits
  assign lo = split_q ? word0_q : mem_rdata;
  assign sh = 32'({mem_rdata, lo} >> {o_q, 3'b0});
  assign ext = len_q == 3'd0 ? {{24{sh[7]}}, sh[7:0]} :
               len_q == 3'd1 ? {{16{sh[15]}}, sh[15:0]} :
               len_q == 3'd3 ? {24'b0, sh[7:0]} :
               len_q == 3'd4 ? {16'b0, sh[15:0]} : sh;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {len_q, o_q, idx_q, be1_q, wd1_q, word0_q, rdata_q} <= '0;
      {ld_q, st_q, split_q, done_q} <= '0;
      {mem_addr, mem_re, mem_we, mem_be, mem_wdata} <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      {trap_q, err_q} <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q <= 1'b0;
`endif
      if (ready && req.req_valid) begin
        state <= B0;
        st_q <= st_in;
        ld_q <= ld_in;
        split_q <= ok && |bef[7:4];
        len_q <= req.MemLen;
        o_q <= req.addr[1:0];
        idx_q <= req.addr[ADDR_WIDTH-1:2];
        be1_q <= bef[7:4];
        wd1_q <= wd64[63:32];
        mem_addr <= req.addr[ADDR_WIDTH-1:2];
        mem_we <= st_in;
        mem_re <= ld_in;
        mem_be <= ok ? bef[3:0] : 4'h0;
        mem_wdata <= wd64[31:0];
`ifdef LSU_MISALIGN_TRAP_EN
        trap_q <= trap;
`endif
      end else if (state == RESP) begin
        state <= IDLE;
      end else if (state == B0 && split_q) begin
        state <= B1;
        mem_addr <= idx_q + 1'b1;
        mem_be <= be1_q;
        mem_wdata <= wd1_q;
      end else if (state == B0 || state == B1) begin
        mem_re <= 1'b0;
        mem_we <= 1'b0;
        mem_be <= 4'h0;
        state <= ld_q ? WAIT : IDLE;
        done_q <= !ld_q;
        if (state == B1) word0_q <= mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
        err_q <= trap_q;
        if (trap_q) rdata_q <= 32'h0;
`endif
      end else if (state == WAIT) begin
        rdata_q <= ext;
        done_q <= 1'b1;
        state <= RESP;
      end
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed + random checks of lsu_ctrl against a byte-array memory model.
module tb_lsu_ctrl;
  logic clk = 0, rst = 1, init = 1;
  logic [7:0] mem_addr;
  logic mem_re, mem_we;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ram [256];
  logic [7:0] ref_mem [1024];
  logic [31:0] ref_rdata = 0;
  logic [7:0] b_addr [2];
  logic [3:0] b_be [2];
  logic [31:0] b_wd [2];
  int cmp_n = 0, err_n = 0;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1;
`else
  localparam bit TRAP_EN = 0;
`endif
  lsu_if #(.ADDR_WIDTH(10)) bus ();
  lsu_ctrl #(.ADDR_WIDTH(10)) dut (.clk(clk), .rst(rst), .req(bus.slave), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (init) begin
      for (int w = 0; w < 256; w++) ram[w] <= {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      mem_rdata <= 0;
    end else begin
      for (int i = 0; i < 4; i++) if (mem_we && mem_be[i]) ram[mem_addr][8*i+:8] <= mem_wdata[8*i+:8];
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_n++;
    assert (got === exp) else begin
      err_n++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int nb(input logic [2:0] l);
    return (l == 0 || l == 3) ? 1 : (l == 1 || l == 4) ? 2 : (l == 2) ? 4 : 0;
  endfunction
  function automatic logic [31:0] mword(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction
  // Called at a negedge; returns at the negedge of the done cycle so the next call is back-to-back
  task automatic do_op(input string tag, input bit w, input bit r, input logic [2:0] l,
                       input logic [9:0] a, input logic [31:0] d);
    int n, o, lat, nre, nwe, nbt, bad, exp_beats, exp_lat;
    bit ld, act, mis, trap, spl;
    logic [31:0] v;
    n = nb(l); o = int'(a) % 4; ld = !w && r; act = n != 0 && (w || r);
    mis = (n == 4 && o != 0) || (n == 2 && o % 2 == 1);
    trap = TRAP_EN && act && mis;
    act = act && !trap;
    spl = o + n > 4;
    exp_beats = act ? (spl ? 2 : 1) : 0;
    exp_lat = !act ? 2 : ld ? (spl ? 4 : 3) : (spl ? 3 : 2);
    if (act && ld) begin
      v = 0;
      for (int i = 0; i < n; i++) v |= 32'(ref_mem[(int'(a) + i) % 1024]) << (8 * i);
      if (l == 0) v = {{24{v[7]}}, v[7:0]};
      if (l == 1) v = {{16{v[15]}}, v[15:0]};
      ref_rdata = v;
    end
    if (act && w) for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 1024] = d[8*i+:8];
    if (trap) ref_rdata = 0;
    bus.req_valid = 1; bus.MemWrite = w; bus.MemRead = r; bus.MemLen = l; bus.addr = a; bus.wdata = d;
    bad = bus.req_ready ? 0 : 1;
    @(posedge clk);
    #1;
    bus.MemWrite = 1; bus.MemLen = 2; bus.addr = 10'($urandom); bus.wdata = $urandom;
    lat = 0; nre = 0; nwe = 0; nbt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        if (nbt < 2) begin b_addr[nbt] = mem_addr; b_be[nbt] = mem_be; b_wd[nbt] = mem_wdata; end
        nbt++; nre += int'(mem_re); nwe += int'(mem_we);
      end else if (mem_be != 0) bad++;
      if (bus.done) begin lat = k; break; end
      if (bus.req_ready) bad++;
    end
    bus.req_valid = 0;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_re"}, nre, (act && ld) ? exp_beats : 0);
    chk({tag, "_we"}, nwe, (act && w) ? exp_beats : 0);
    chk({tag, "_rdata"}, bus.rdata, ref_rdata);
    chk({tag, "_err"}, 32'(bus.misalign_err), 32'(trap));
    chk({tag, "_hs"}, bad, 0);
  endtask
  initial begin
    bus.req_valid = 0; bus.MemRead = 0; bus.MemWrite = 0; bus.MemLen = 0; bus.addr = 0; bus.wdata = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i);
    @(negedge clk); @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_outs", {bus.done, bus.misalign_err, mem_re, mem_we, mem_be}, 0);
    chk("rst_rdata", bus.rdata, 0);
    init = 0; rst = 0;
    @(negedge clk);
    do_op("lw010", 0, 1, 2, 10'h010, 0);
    chk("lw010_val", bus.rdata, 32'h13121110);
    chk("lw010_beat", {b_addr[0], b_be[0]}, {8'd4, 4'hF});
    do_op("lb083", 0, 1, 0, 10'h083, 0);
    chk("lb083_val", bus.rdata, 32'hFFFFFF83);
    do_op("lbu083", 0, 1, 3, 10'h083, 0);
    chk("lbu083_val", bus.rdata, 32'h00000083);
    do_op("lh082", 0, 1, 1, 10'h082, 0);
    chk("lh082_val", bus.rdata, 32'hFFFF8382);
    do_op("lw00e", 0, 1, 2, 10'h00E, 0);
    do_op("sh007", 1, 0, 1, 10'h007, 32'h0000BEEF);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("sh007_b0", {b_addr[0], b_be[0], b_wd[0][31:24]}, {8'd1, 4'h8, 8'hEF});
    chk("sh007_b1", {b_addr[1], b_be[1], b_wd[1][7:0]}, {8'd2, 4'h1, 8'hBE});
`endif
    do_op("lhu007", 0, 1, 4, 10'h007, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lhu007_val", bus.rdata, 32'h0000BEEF);
`endif
    do_op("sw3fd", 1, 0, 2, 10'h3FD, 32'hDEADBEEF);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("sw3fd_wrap", {b_addr[0], b_addr[1]}, {8'd255, 8'd0});
    chk("sw3fd_w0", ram[0], mword(0));
    // Same split store, reset pulsed while beat 1 is on the bus
    bus.req_valid = 1; bus.MemWrite = 1; bus.MemRead = 0; bus.MemLen = 2; bus.addr = 10'h3FD; bus.wdata = 32'hCAFEF00D;
    @(posedge clk); #1 bus.req_valid = 0;
    @(negedge clk); @(negedge clk);
    chk("rmid_b1", {mem_we, mem_addr}, {1'b1, 8'd0});
    rst = 1;
    #1 chk("rmid_drop", {mem_we, mem_re, mem_be}, 0);
    ref_mem[1021] = 8'h0D; ref_mem[1022] = 8'hF0; ref_mem[1023] = 8'hFE; ref_rdata = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    begin
      int dn = 0;
      for (int k = 0; k < 4; k++) begin @(negedge clk); dn += int'(bus.done); end
      chk("rmid_nodone", dn, 0);
    end
    chk("rmid_ready", 32'(bus.req_ready), 1);
    chk("rmid_w255", ram[255], mword(255));
    chk("rmid_w0", ram[0], mword(0));
`endif
    for (int t = 0; t < 300; t++) begin
      bit w, r;
      logic [2:0] l;
      w = $urandom_range(0, 2) == 0; r = $urandom_range(0, 4) != 0;
      l = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      do_op("rnd", w, r, l, 10'($urandom), $urandom);
    end
    for (int w = 0; w < 256; w++) chk("ram_final", ram[w], mword(w));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator for the MEM stage.
- Accepts one load or store request from the pipeline and drives a word-organised, byte-enabled synchronous data RAM.
- Splits accesses that cross a word boundary into two word beats.
- Assembles and sign/zero-extends load data, then returns it with a one-cycle done pulse.
- Uses the same MemLen encoding as the stage: 0 LB, 1 LH, 2 LW/SW, 3 LBU, 4 LHU.

Parameters:
- ADDR_WIDTH, 10, byte-address width. RAM word index width is ADDR_WIDTH-2.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  block idle, request accepted this cycle if req_valid
- MemRead  input  1  load request
- MemWrite  input  1  store request; priority over MemRead if both set
- MemLen  input  3  access size/extension code
- addr  input  ADDR_WIDTH  byte address
- wdata  input  32  store data, right-justified
- rdata  output  32  extended load result, valid with done
- done  output  1  one-cycle completion pulse
- misalign_err  output  1  see Optional Feature
- mem_addr  output  ADDR_WIDTH-2  RAM word index
- mem_re  output  1  RAM read strobe
- mem_we  output  1  RAM write strobe
- mem_be  output  4  RAM byte enables, bit i = byte lane i
- mem_wdata  output  32  lane-aligned write data
- mem_rdata  input  32  RAM read data, valid the cycle after mem_re

Behaviour:
- Reset (async, immediate): state IDLE. req_ready=1; all other outputs 0.
- FSM states: IDLE, B0, B1, WAIT, RESP.
- Accept: IDLE & req_valid at edge E0. Latch op, MemLen, addr, wdata; req_ready=0 from E0.
- Derived values: size n = 1/2/4 bytes, o = addr[1:0], split = (o+n>4).
- Beat 0: mem_addr = addr[ADDR_WIDTH-1:2]; mem_be = (2^n-1)<<o, truncated to 4 bits; mem_wdata = wdata<<(8*o).
- Beat 1: mem_addr = beat-0 index+1, wrapping modulo 2^(ADDR_WIDTH-2); mem_be = (2^n-1)>>(4-o); mem_wdata = wdata>>(8*(4-o)).
- mem_re/mem_we/mem_be/mem_addr/mem_wdata are registered. Strobes are high only in B0/B1. mem_be=0 whenever no strobe is high.
- Aligned store: B0 (we) -> IDLE. done=1 in cycle E0+2.
- Split store: B0 -> B1 -> IDLE. done in cycle E0+3.
- Aligned load: B0 (re) -> WAIT (capture word0) -> RESP. rdata and done registered; done high in cycle E0+3.
- Split load: B0 -> B1 (re word1, capture word0) -> WAIT (capture word1) -> RESP. done in E0+4.
- Load assembly: take {word1,word0}>>(8*o), low n bytes.
  - Sign-extend for MemLen 0/1.
  - Zero-extend for 3/4.
  - Pass through for 2.
- done is high exactly one cycle. req_ready returns to 1 in the same cycle done pulses, so back-to-back requests are accepted with that cycle as the next accept.
- rdata holds its value until the next load completes. Stores do not alter rdata.
- MemLen 5-7, or neither MemRead nor MemWrite set:
  - Accepted, no strobe issued.
  - done in E0+2; rdata unchanged.
- req_valid while busy is ignored, not queued.
- Reset mid-operation:
  - Strobes drop at once.
  - No done is issued.
  - A second beat not yet issued is never written.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access (o!=0 for word; o[0]=1 for half) issues no strobe. Instead misalign_err=1 and done=1 together in cycle E0+2, and rdata is forced to 0.
- Undefined: misaligned accesses split as above; misalign_err is constant 0.

Test Plan:
(RAM preloaded so that byte at address a = a[7:0].)
- LW addr 0x010 -> mem_addr=4, mem_be=1111, mem_re one cycle; done at E0+3, rdata=0x13121110.
- LB addr 0x083 -> rdata=0xFFFFFF83. LBU 0x083 -> 0x00000083. LH 0x082 -> 0xFFFF8382.
- LW addr 0x00E (split) -> reads at mem_addr 3 then 4; done at E0+4, rdata=0x11100F0E.
- SH wdata=0x0000BEEF addr 0x007 -> beat0 mem_addr=1 be=1000 mem_wdata[31:24]=0xEF; beat1 mem_addr=2 be=0001 mem_wdata[7:0]=0xBE; then LHU 0x007 -> 0x0000BEEF.
- SW 0xDEADBEEF at addr 0x3FD (ADDR_WIDTH=10, split) -> beat0 mem_addr=255, beat1 mem_addr=0 (wrap). Repeat with rst pulsed during B1: beat-1 word unchanged, no done, req_ready=1 after release.
- With LSU_MISALIGN_TRAP_EN: LW 0x00E -> no mem_re, misalign_err=done=1 at E0+2, rdata=0; LW 0x010 behaves as in the first scenario.
